// File: rtl/i2c_master_wr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_master_wr                                                |
// | Description : Single-register I2C write master with open-drain pads:       |
// |               START, {addr,W}, register address, data byte, STOP.          |
// |               Optional macro I2C_MASTER_ACK_CHK_EN aborts to STOP on NACK. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module i2c_master_wr #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         QDIV     = 125
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    inout  wire        Pad_SCL,
    inout  wire        Pad_SDA
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BIT   = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam logic [9:0] c_qmax = 10'(QDIV - 1);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [9:0] r_qcnt;
    logic [1:0] r_quarter;
    logic [2:0] r_bit;
    logic [1:0] r_byte;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic       r_ack_err;

    logic       w_qwrap;
    logic       w_phase_end;
    logic       w_abort;
    logic [7:0] w_tx_byte;
    logic       w_tx_bit;
    logic       w_scl_low;
    logic       w_sda_low;

    assign w_qwrap     = (r_qcnt == c_qmax);
    assign w_phase_end = w_qwrap &&
                         ((r_state == S_START) ? (r_quarter == 2'd1) : (r_quarter == 2'd3));

`ifdef I2C_MASTER_ACK_CHK_EN
    // A NACK seen in the current slot sends the bus straight to STOP.
    assign w_abort = r_ack_err;
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_tx_byte = r_data;
        case (r_byte)
            2'd0:    w_tx_byte = {SLV_ADDR, 1'b0};
            2'd1:    w_tx_byte = r_addr;
            default: w_tx_byte = r_data;
        endcase
    end

    assign w_tx_bit = w_tx_byte[r_bit];

    // State register
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (wr_req) w_state_nxt = S_START;
            S_START: if (w_phase_end) w_state_nxt = S_BIT;
            S_BIT:   if (w_phase_end && (r_bit == 3'd0)) w_state_nxt = S_ACK;
            S_ACK: begin
                if (w_phase_end) begin
                    w_state_nxt = ((r_byte == 2'd2) || w_abort) ? S_STOP : S_BIT;
                end
            end
            S_STOP:  if (w_phase_end) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Quarter timing, bit/byte position, request latch and ACK sampling
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_qcnt    <= 10'd0;
            r_quarter <= 2'd0;
            r_bit     <= 3'd0;
            r_byte    <= 2'd0;
            r_addr    <= 8'h00;
            r_data    <= 8'h00;
            r_ack_err <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_qcnt    <= 10'd0;
            r_quarter <= 2'd0;
            r_bit     <= 3'd7;
            r_byte    <= 2'd0;
            if (wr_req) begin
                r_addr    <= wr_addr;
                r_data    <= wr_data;
                r_ack_err <= 1'b0;
            end
        end else if (r_state != S_FIN) begin
            r_qcnt <= w_qwrap ? 10'd0 : (r_qcnt + 10'd1);
            if (w_qwrap) begin
                r_quarter <= w_phase_end ? 2'd0 : (r_quarter + 2'd1);
            end
            // Last clock of q1: SCL has been high for a full quarter.
            if ((r_state == S_ACK) && (r_quarter == 2'd1) && w_qwrap && Pad_SDA) begin
                r_ack_err <= 1'b1;
            end
            if (w_phase_end && (r_state == S_BIT) && (r_bit != 3'd0)) begin
                r_bit <= r_bit - 3'd1;
            end
            if (w_phase_end && (r_state == S_ACK)) begin
                r_bit  <= 3'd7;
                r_byte <= r_byte + 2'd1;
            end
        end
    end

    // Output decode
    always_comb begin
        w_scl_low = 1'b0;
        w_sda_low = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_START: begin
                busy      = 1'b1;
                w_sda_low = (r_quarter == 2'd1);
            end
            S_BIT: begin
                busy      = 1'b1;
                w_scl_low = (r_quarter == 2'd0) || (r_quarter == 2'd3);
                w_sda_low = ~w_tx_bit;
            end
            S_ACK: begin
                busy      = 1'b1;
                w_scl_low = (r_quarter == 2'd0) || (r_quarter == 2'd3);
            end
            S_STOP: begin
                busy      = 1'b1;
                w_scl_low = (r_quarter == 2'd0);
                w_sda_low = (r_quarter == 2'd0) || (r_quarter == 2'd1);
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign Pad_SCL = w_scl_low ? 1'b0 : 1'bz;
    assign Pad_SDA = w_sda_low ? 1'b0 : 1'bz;
    assign ack_err = r_ack_err;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_wr.sv
`default_nettype none
// Bench for i2c_master_wr: table of writes against a behavioural I2C register slave,
// plus a hand-written mid-transaction reset sequence.
module tb_i2c_master_wr;

    localparam int TQ     = 8;
    localparam int T_FULL = 114 * TQ;
    localparam int T_NACK = 42 * TQ;

    logic       clk_50M;
    logic       rst_n;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       ack_err;
    wire        scl_bus;
    wire        sda_bus;

    pullup (scl_bus);
    pullup (sda_bus);

    logic slv_pull;
    assign sda_bus = slv_pull ? 1'b0 : 1'bz;

    i2c_master_wr #(
        .SLV_ADDR (7'h50),
        .QDIV     (TQ)
    ) dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .wr_req  (wr_req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .Pad_SCL (scl_bus),
        .Pad_SDA (sda_bus)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    // Behavioural slave: decodes START/STOP, bytes, drives ACK, keeps registers.
    logic       slave_nack;
    logic       scl_q, sda_q, in_ack, addr_ok;
    int         bitcnt, nbytes, n_stop, n_wr, done_cnt;
    logic [7:0] sh, ptr;
    logic [7:0] rx [0:2];
    logic [7:0] regs [0:255];

    initial begin
        slv_pull = 1'b0; scl_q = 1'b1; sda_q = 1'b1; in_ack = 1'b0; addr_ok = 1'b0;
        bitcnt = 0; nbytes = 0; n_stop = 0; n_wr = 0; sh = 8'h00; ptr = 8'h00;
    end

    always @(negedge clk_50M) begin
        if (scl_q && scl_bus && sda_q && !sda_bus) begin
            bitcnt = 0; nbytes = 0; in_ack = 1'b0; slv_pull = 1'b0; addr_ok = 1'b0;
            rx[0] = 8'h00; rx[1] = 8'h00; rx[2] = 8'h00;
        end else if (scl_q && scl_bus && !sda_q && sda_bus) begin
            n_stop++;
        end else if (!scl_q && scl_bus) begin
            if (!in_ack && bitcnt < 8) begin
                sh = {sh[6:0], sda_bus};
                bitcnt++;
            end
        end else if (scl_q && !scl_bus) begin
            if (in_ack) begin
                in_ack = 1'b0; slv_pull = 1'b0; bitcnt = 0;
            end else if (bitcnt == 8) begin
                in_ack = 1'b1;
                if (nbytes < 3) rx[nbytes] = sh;
                if (nbytes == 0) addr_ok = (sh == 8'hA0) && !slave_nack;
                else if (nbytes == 1) ptr = sh;
                else if (nbytes == 2 && addr_ok) begin
                    regs[ptr] = sh;
                    n_wr++;
                end
                nbytes++;
                slv_pull = addr_ok;
            end
        end
        scl_q = scl_bus;
        sda_q = sda_bus;
    end

    initial done_cnt = 0;
    always @(negedge clk_50M) if (done === 1'b1) done_cnt++;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        bit         nack;
        int         extra_at;
        int         exp_cyc;
        int         exp_nbytes;
        logic [7:0] exp_b1;
        logic [7:0] exp_b2;
        logic       exp_err;
    } vec_t;

    vec_t vecs [0:6];

    task automatic run_vec(input int id, input vec_t v);
        int cyc;
        int d0, s0;
        cyc = 0;
        slave_nack = v.nack;
        @(negedge clk_50M);
        d0 = done_cnt;
        s0 = n_stop;
        wr_addr = v.addr; wr_data = v.data; wr_req = 1'b1;
        @(negedge clk_50M);
        wr_req = 1'b0;
        check($sformatf("v%0d_busy_rise", id), busy, 1);
        check($sformatf("v%0d_ackerr_clr", id), ack_err, 0);
        while (done !== 1'b1 && cyc < T_FULL + 50) begin
            @(negedge clk_50M);
            cyc++;
            wr_req = (cyc == v.extra_at);
        end
        wr_req = 1'b0;
        check($sformatf("v%0d_done_cyc", id), cyc, v.exp_cyc);
        check($sformatf("v%0d_busy_at_done", id), busy, 0);
        check($sformatf("v%0d_ack_err", id), ack_err, v.exp_err);
        repeat (4) @(negedge clk_50M);
        check($sformatf("v%0d_done_pulses", id), done_cnt - d0, 1);
        check($sformatf("v%0d_stops", id), n_stop - s0, 1);
        check($sformatf("v%0d_ack_err_hold", id), ack_err, v.exp_err);
        check($sformatf("v%0d_idle_busy", id), busy, 0);
        check($sformatf("v%0d_nbytes", id), nbytes, v.exp_nbytes);
        check($sformatf("v%0d_byte0", id), rx[0], 8'hA0);
        if (v.exp_nbytes > 1) begin
            check($sformatf("v%0d_byte1", id), rx[1], v.exp_b1);
            check($sformatf("v%0d_byte2", id), rx[2], v.exp_b2);
        end
    endtask

    initial begin
        vec_t v;
        int cyc, d0, w0;
        rst_n = 1'b0; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00; slave_nack = 1'b0;

        vecs[0] = '{8'h01, 8'h5A, 1'b0, -1,  T_FULL, 3, 8'h01, 8'h5A, 1'b0};
        vecs[1] = '{8'h00, 8'h00, 1'b0, -1,  T_FULL, 3, 8'h00, 8'h00, 1'b0};
        vecs[2] = '{8'h01, 8'h01, 1'b0, -1,  T_FULL, 3, 8'h01, 8'h01, 1'b0};
        vecs[3] = '{8'h02, 8'h02, 1'b0, -1,  T_FULL, 3, 8'h02, 8'h02, 1'b0};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 100, T_FULL, 3, 8'h7F, 8'hFF, 1'b0};
`ifdef I2C_MASTER_ACK_CHK_EN
        vecs[5] = '{8'h33, 8'hCC, 1'b1, -1,  T_NACK, 1, 8'h00, 8'h00, 1'b1};
`else
        vecs[5] = '{8'h33, 8'hCC, 1'b1, -1,  T_FULL, 3, 8'h33, 8'hCC, 1'b1};
`endif
        vecs[6] = '{8'h80, 8'h81, 1'b0, -1,  T_FULL, 3, 8'h80, 8'h81, 1'b0};

        repeat (3) @(negedge clk_50M);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_scl", scl_bus, 1);
        check("rst_sda", sda_bus, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50M);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        check("reg00", regs[8'h00], 8'h00);
        check("reg01", regs[8'h01], 8'h01);
        check("reg02", regs[8'h02], 8'h02);
        check("reg7F", regs[8'h7F], 8'hFF);
        check("reg80", regs[8'h80], 8'h81);

        // Reset while the register-address byte is on the bus.
        slave_nack = 1'b0;
        d0 = done_cnt;
        w0 = n_wr;
        cyc = 0;
        @(negedge clk_50M);
        wr_addr = 8'h05; wr_data = 8'h77; wr_req = 1'b1;
        @(negedge clk_50M);
        wr_req = 1'b0;
        while (cyc < 42 * TQ + 3) begin
            @(negedge clk_50M);
            cyc++;
        end
        check("abort_pre_scl", scl_bus, 0);
        check("abort_pre_sda", sda_bus, 0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_scl_z", scl_bus, 1);
        check("abort_sda_z", sda_bus, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (3) @(negedge clk_50M);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_50M);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_write", n_wr - w0, 0);

        v = '{8'h03, 8'h3C, 1'b0, -1, T_FULL, 3, 8'h03, 8'h3C, 1'b0};
        run_vec(7, v);
        check("reg03", regs[8'h03], 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_master_wr.md
I2C_MASTER_WR -- requirements
Module: i2c_master_wr

Interface
REQ-001 Parameter SLV_ADDR, default 7'h50: 7-bit target address sent in the address byte.
REQ-002 Parameter QDIV, default 125: clk_50M cycles per SCL quarter-period (100 kHz at 50 MHz); legal range 4..1023.
REQ-003 clk_50M  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 wr_req  input  1  single-cycle request to start one register write.
REQ-006 wr_addr  input  8  target register address.
REQ-007 wr_data  input  8  byte to write.
REQ-008 busy  output  1  high while a transaction is in progress.
REQ-009 done  output  1  one-cycle pulse at transaction end.
REQ-010 ack_err  output  1  high if any ACK slot sampled high in the last transaction.
REQ-011 Pad_SCL  inout  1  open-drain clock: drives 0 or releases to Z, never drives 1.
REQ-012 Pad_SDA  inout  1  open-drain data: drives 0 or releases to Z; read back for ACK.

Function
REQ-013 wr_req sampled while busy=0 is accepted: wr_addr/wr_data latched, busy=1 from the next cycle.
REQ-014 wr_req while busy=1 is ignored; it is not queued.
REQ-015 Quarter counter runs 0..QDIV-1 and advances the phase on wrap; every phase lasts exactly QDIV clocks.
REQ-016 States: IDLE, START, BIT, ACK, STOP, FIN; FIN lasts one clock.
REQ-017 START, 2 quarters: q0 SCL/SDA released; q1 SDA low, SCL released.
REQ-018 BIT/ACK slot, 4 quarters: q0 SCL low, SDA updated; q1,q2 SCL released; q3 SCL low.
REQ-019 Bits are sent MSB first; SDA is 0 for a 0 bit and Z for a 1 bit.
REQ-020 Byte order: {SLV_ADDR,1'b0}, wr_addr, wr_data; each byte is followed by one ACK slot.
REQ-021 In an ACK slot SDA is released and Pad_SDA is sampled on the last clock of q1.
REQ-022 STOP, 4 quarters: q0 SCL low, SDA low; q1 SCL released, SDA low; q2,q3 both released.
REQ-023 Full transaction = (2 + 27*4 + 4) * QDIV clocks; 14250 clocks at default.
REQ-024 FIN: done=1 for one clock, busy=0 in the same cycle; the next IDLE cycle may accept wr_req.
REQ-025 ack_err clears on acceptance of a new wr_req and holds its value after done.
REQ-026 Pad_SCL/Pad_SDA are released (Z) in IDLE and FIN.

Reset
REQ-027 rst_n low immediately (asynchronously) forces IDLE; Pad_SCL=Z, Pad_SDA=Z, busy=0, done=0, ack_err=0, counters=0.
REQ-028 Reset mid-transaction aborts without STOP and produces no done pulse; operation resumes with the next wr_req after release.

Configuration
REQ-029 Macro I2C_MASTER_ACK_CHK_EN defined: a high ACK sample sets ack_err and jumps to STOP at the next slot boundary; remaining bytes are skipped.
REQ-030 Macro I2C_MASTER_ACK_CHK_EN undefined: ack_err still records a NACK, but all three bytes are always sent.

Verification
REQ-031 wr_req, wr_addr=8'h01, wr_data=8'h5A, slave ACKs -> SDA bytes 8'hA0, 8'h01, 8'h5A; STOP; done at clock 14250 after busy rises; ack_err=0.
REQ-032 Drive the pads into I2C_trx and issue writes (0,0), (1,1), (2,2) -> three done pulses, ack_err=0, and I2C_trx registers 0..2 hold 0, 1, 2.
REQ-033 With the macro, slave NACKs the address byte -> ack_err=1, STOP right after the first ACK slot, done at (2+9*4+4)*QDIV clocks.
REQ-034 Without the macro, the same NACK -> all 27 bit slots are sent, ack_err=1, done at 14250 clocks.
REQ-035 wr_req pulsed at clock 100 of a transaction -> no effect; exactly one done pulse.
REQ-036 rst_n low during the wr_addr byte -> both pads Z in the same cycle, busy=0, no done; a later write completes normally.
